gshare_pht: RTL and testbench

Parametrised gshare pattern history table for the branch predictor, one generation beyond the plain indexed PHT. It XOR-folds a speculative global history register into the fetch index and owns saturating-counter arithmetic internally. It also clears its own storage after reset and repairs history on mispredict. It sits between IF, which reads a prediction per fetch, and EX/MEM, which trains it with resolved branches.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/gshare_pht_if.sv | 30 +++
 rtl/pht_ram.sv | 23 ++
 rtl/gshare_pht.sv | 86 ++++++++
 tb/tb_gshare_pht.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter/hash helpers for the gshare branch predictor.
package bp_pkg;

  typedef enum logic [0:0] {INIT, RUN} state_e;

  function automatic int unsigned weakly_nt(int unsigned count);
    return (32'd1 << (count - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned sat_inc(int unsigned val, int unsigned count);
    return (val == ((32'd1 << count) - 32'd1)) ? val : val + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(int unsigned val);
    return (val == 32'd0) ? val : val - 32'd1;
  endfunction

  // History is zero-extended into the low index bits before folding.
  function automatic int unsigned hash(int unsigned index, int unsigned hist);
    return index ^ hist;
  endfunction

endpackage

// File: rtl/gshare_pht_if.sv
// Fetch lookup and EX/MEM training signals between the pipeline and the gshare PHT.
interface gshare_pht_if #(
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned COUNT      = 2,
  parameter int unsigned HIST       = 5
);
  logic                  fetch_valid_in;
  logic [INDEX_BITS-1:0] fetch_index_in;
  logic                  fetch_taken_out;
  logic [COUNT-1:0]      fetch_confidence_out;
  logic [HIST-1:0]       fetch_hist_out;
  logic                  ready_out;
  logic                  update_in;
  logic [INDEX_BITS-1:0] exmem_index_in;
  logic [HIST-1:0]       exmem_hist_in;
  logic                  exmem_taken_in;
  logic                  mispredict_in;

  modport master (
    output fetch_valid_in, fetch_index_in, update_in, exmem_index_in, exmem_hist_in,
           exmem_taken_in, mispredict_in,
    input  fetch_taken_out, fetch_confidence_out, fetch_hist_out, ready_out
  );

  modport slave (
    input  fetch_valid_in, fetch_index_in, update_in, exmem_index_in, exmem_hist_in,
           exmem_taken_in, mispredict_in,
    output fetch_taken_out, fetch_confidence_out, fetch_hist_out, ready_out
  );
endinterface

// File: rtl/pht_ram.sv
// Counter storage: two combinational read ports (fetch, update) and one synchronous write port.
module pht_ram #(
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned COUNT      = 2
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] fetch_idx,
  output logic [COUNT-1:0]      fetch_data,
  input  logic [INDEX_BITS-1:0] upd_idx,
  output logic [COUNT-1:0]      upd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [COUNT-1:0]      wr_data
);
  logic [COUNT-1:0] mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign fetch_data = mem[fetch_idx];
  assign upd_data   = mem[upd_idx];
endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: GHR-hashed lookup, saturating training, init sweep, GHR repair.
// Optional same-cycle update-to-fetch forwarding is compiled in with PHT_BYPASS_EN.
module gshare_pht
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned COUNT      = 2,
  parameter int unsigned HIST       = 5
) (
  input  logic       clk_in,
  input  logic       rst_in,
  gshare_pht_if.slave bus
);
  localparam int unsigned            Entries   = 2**INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LastEntry = INDEX_BITS'(Entries - 1);
  localparam logic [COUNT-1:0]      InitCount = COUNT'(weakly_nt(COUNT));

  state_e                state_q;
  logic [INDEX_BITS-1:0] sweep_q;
  logic [HIST-1:0]       ghr_q;

  logic                  running;
  logic [INDEX_BITS-1:0] fetch_hash, upd_hash, wr_idx;
  logic [COUNT-1:0]      fetch_rd, upd_rd, upd_cnt, wr_data, fetch_cnt;
  logic                  ram_we;

  assign running    = (state_q == RUN);
  assign fetch_hash = INDEX_BITS'(hash(32'(bus.fetch_index_in), 32'(ghr_q)));
  assign upd_hash   = INDEX_BITS'(hash(32'(bus.exmem_index_in), 32'(bus.exmem_hist_in)));
  assign upd_cnt    = bus.exmem_taken_in ? COUNT'(sat_inc(32'(upd_rd), COUNT))
                                         : COUNT'(sat_dec(32'(upd_rd)));

  // The sweep owns the write port until the table is fully initialised.
  assign ram_we  = !running || bus.update_in;
  assign wr_idx  = running ? upd_hash : sweep_q;
  assign wr_data = running ? upd_cnt : InitCount;

  pht_ram #(
    .INDEX_BITS (INDEX_BITS),
    .COUNT      (COUNT)
  ) u_ram (
    .clk        (clk_in),
    .fetch_idx  (fetch_hash),
    .fetch_data (fetch_rd),
    .upd_idx    (upd_hash),
    .upd_data   (upd_rd),
    .we         (ram_we),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data)
  );

`ifdef PHT_BYPASS_EN
  assign fetch_cnt = (running && bus.update_in && (upd_hash == fetch_hash)) ? upd_cnt : fetch_rd;
`else
  assign fetch_cnt = fetch_rd;
`endif

  assign bus.fetch_confidence_out = fetch_cnt;
  assign bus.fetch_taken_out      = fetch_cnt[COUNT-1];
  assign bus.fetch_hist_out       = ghr_q;
  assign bus.ready_out            = running;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          sweep_q <= sweep_q + INDEX_BITS'(1);
          if (sweep_q == LastEntry) state_q <= RUN;
        end
        RUN: begin
          // Truncating casts keep the low HIST bits, so HIST=1 degenerates to a plain load.
          if (bus.update_in && bus.mispredict_in) begin
            ghr_q <= HIST'({bus.exmem_hist_in, bus.exmem_taken_in});
          end else if (bus.fetch_valid_in) begin
            ghr_q <= HIST'({ghr_q, fetch_cnt[COUNT-1]});
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: init timing, training, GHR shift/repair, collision, re-reset.
module tb_gshare_pht;
  localparam int unsigned IB = 5;
  localparam int unsigned CW = 2;
  localparam int unsigned HB = 5;

`ifdef PHT_BYPASS_EN
  localparam logic [1:0] BypConf  = 2'd2;
  localparam logic       BypTaken = 1'b1;
`else
  localparam logic [1:0] BypConf  = 2'd1;
  localparam logic       BypTaken = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       fv;
    logic [4:0] fidx;
    logic       upd;
    logic [4:0] uidx;
    logic [4:0] uhist;
    logic       utk;
    logic       mis;
    logic [1:0] e_conf;
    logic       e_tk;
    logic [4:0] e_hist;
    logic       e_rdy;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] conf;
    logic       tk;
    logic [4:0] hist;
    logic       rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  gshare_pht_if #(.INDEX_BITS(IB), .COUNT(CW), .HIST(HB)) bus ();

  gshare_pht #(.INDEX_BITS(IB), .COUNT(CW), .HIST(HB)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic fv, logic [4:0] fidx, logic upd, logic [4:0] uidx,
                              logic [4:0] uhist, logic utk, logic mis, logic [1:0] ec,
                              logic et, logic [4:0] eh);
    vec_t v;
    v.name = nm; v.fv = fv; v.fidx = fidx; v.upd = upd; v.uidx = uidx; v.uhist = uhist;
    v.utk = utk; v.mis = mis; v.e_conf = ec; v.e_tk = et; v.e_hist = eh; v.e_rdy = 1'b1;
    return v;
  endfunction

  // Starts just after a rising edge, ends just after the next one.
  task automatic run_vec(input vec_t v);
    exp_t e, got;
    bus.fetch_valid_in = v.fv;
    bus.fetch_index_in = v.fidx;
    bus.update_in      = v.upd;
    bus.exmem_index_in = v.uidx;
    bus.exmem_hist_in  = v.uhist;
    bus.exmem_taken_in = v.utk;
    bus.mispredict_in  = v.mis;
    e.name = v.name; e.conf = v.e_conf; e.tk = v.e_tk; e.hist = v.e_hist; e.rdy = v.e_rdy;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({got.name, "_conf"}, 32'(bus.fetch_confidence_out), 32'(got.conf));
      chk({got.name, "_taken"}, 32'(bus.fetch_taken_out), 32'(got.tk));
      chk({got.name, "_hist"}, 32'(bus.fetch_hist_out), 32'(got.hist));
      chk({got.name, "_ready"}, 32'(bus.ready_out), 32'(got.rdy));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_valid_in = 1'b0;
    bus.fetch_index_in = '0;
    bus.update_in      = 1'b0;
    bus.exmem_index_in = '0;
    bus.exmem_hist_in  = '0;
    bus.exmem_taken_in = 1'b0;
    bus.mispredict_in  = 1'b0;
  endtask

  task automatic read_all(input string nm);
    for (int i = 0; i < 32; i++) run_vec(mk(nm, 0, 5'(i), 0, 0, 0, 0, 0, 2'd1, 0, 5'd0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    // Ready timing after a single-cycle reset.
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      chk($sformatf("init_ready_c%0d", c), 32'(bus.ready_out), (c == 33) ? 32'd1 : 32'd0);
      if (c == 1) chk("init_hist", 32'(bus.fetch_hist_out), 32'd0);
      @(posedge clk);
      #1;
    end
    read_all("init_read");

    // Training, GHR shift, mispredict repair, collision.
    tbl.push_back(mk("rd3_0",   0, 3,  0, 0, 0,  0, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("u3_t1",   0, 0,  1, 3, 0,  1, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("rd3_1",   0, 3,  0, 0, 0,  0, 0, 2'd2, 1, 5'd0));
    tbl.push_back(mk("u3_t2",   0, 0,  1, 3, 0,  1, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("rd3_2",   0, 3,  0, 0, 0,  0, 0, 2'd3, 1, 5'd0));
    tbl.push_back(mk("u3_t3",   0, 0,  1, 3, 0,  1, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("rd3_sat", 0, 3,  0, 0, 0,  0, 0, 2'd3, 1, 5'd0));
    tbl.push_back(mk("u3_n1",   0, 0,  1, 3, 0,  0, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("rd3_4",   0, 3,  0, 0, 0,  0, 0, 2'd2, 1, 5'd0));
    tbl.push_back(mk("u3_n2",   0, 0,  1, 3, 0,  0, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("rd3_5",   0, 3,  0, 0, 0,  0, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("u10_a",   0, 0,  1, 8, 2,  1, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("u10_b",   0, 0,  1, 8, 2,  1, 0, 2'd1, 0, 5'd0));
    tbl.push_back(mk("rd10",    0, 10, 0, 0, 0,  0, 0, 2'd3, 1, 5'd0));
    tbl.push_back(mk("ghr0",    1, 10, 0, 0, 0,  0, 0, 2'd3, 1, 5'd0));
    tbl.push_back(mk("ghr1",    1, 11, 0, 0, 0,  0, 0, 2'd3, 1, 5'd1));
    tbl.push_back(mk("ghr2",    1, 9,  0, 0, 0,  0, 0, 2'd3, 1, 5'd3));
    tbl.push_back(mk("ghr3",    1, 13, 0, 0, 0,  0, 0, 2'd3, 1, 5'd7));
    tbl.push_back(mk("ghr4",    1, 5,  0, 0, 0,  0, 0, 2'd3, 1, 5'd15));
    tbl.push_back(mk("ghr_all", 0, 0,  0, 0, 0,  0, 0, 2'd1, 0, 5'd31));
    tbl.push_back(mk("mispred", 1, 0,  1, 0, 22, 1, 1, 2'd1, 0, 5'd31));
    tbl.push_back(mk("repair",  0, 27, 0, 0, 0,  0, 0, 2'd2, 1, 5'd13));
    tbl.push_back(mk("collide", 0, 10, 1, 7, 0,  1, 0, BypConf, BypTaken, 5'd13));
    tbl.push_back(mk("post_col", 0, 10, 0, 0, 0, 0, 0, 2'd2, 1, 5'd13));
    tbl.push_back(mk("mis_noupd", 1, 10, 0, 0, 0, 0, 1, 2'd2, 1, 5'd13));
    tbl.push_back(mk("shift_in1", 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 5'd27));
    foreach (tbl[i]) run_vec(tbl[i]);
    idle_inputs();

    // Reset again, then reset mid-sweep at entry 20 with updates and fetches during INIT.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.fetch_valid_in = 1'b1;
    bus.exmem_index_in = 5'd5;
    bus.exmem_taken_in = 1'b1;
    bus.mispredict_in  = 1'b1;
    bus.exmem_hist_in  = 5'd0;
    bus.update_in      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      bus.update_in      = (c <= 32);
      bus.fetch_valid_in = (c <= 32);
      @(negedge clk);
      chk($sformatf("rerst_ready_c%0d", c), 32'(bus.ready_out), (c == 33) ? 32'd1 : 32'd0);
      if (c == 33) chk("rerst_hist", 32'(bus.fetch_hist_out), 32'd0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    read_all("rerst_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
